wbu_csr_commit: RTL and testbench
=================================

# wbu_csr_commit

Write-back-stage CSR commit sequencer that turns retiring CSR and trap instructions into single-port write strobes for the IDU CSR file (`CSRWr`, `WBU_csr_rd`, `csr_busW`).
- It computes the `csrrw`/`csrrs`/`csrrc` result from the old value read at decode.
- It serialises the two-CSR `ecall` update (mepc, then mcause) over consecutive cycles.
- It issues the PC redirect for `ecall` and `mret`.
- It stalls the upstream pipeline through a valid/ready handshake while a sequence is in flight.

## Interface
Parameters:
- `ECALL_CAUSE`, default 32'hb: value written to mcause on `ecall`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  commit request present.
- `in_ready`  out  1  block can accept a request; high only in IDLE.
- `in_op`  in  3  operation: NONE=0, CSRRW=1, CSRRS=2, CSRRC=3, ECALL=4, MRET=5. Codes 6 and 7 are treated as NONE.
- `in_csr_rd`  in  3  CSR index: mstatus=0, mtvec=1, mepc=2, mcause=3, mvendorid=4, marchid=5.
- `in_csr_old`  in  32  CSR value read at decode.
- `in_src`  in  32  rs1 value or zero-extended zimm.
- `in_pc`  in  32  PC of the committing instruction.
- `in_mtvec`  in  32  current mtvec value.
- `in_mepc`  in  32  current mepc value.
- `CSRWr`  out  1  CSR write enable.
- `WBU_csr_rd`  out  3  CSR write index.
- `csr_busW`  out  32  CSR write data.
- `redirect_valid`  out  1  one-cycle PC redirect strobe.
- `redirect_pc`  out  32  redirect target.
- `busy`  out  1  state is not IDLE.

## Operation
Handshake and capture:
- A transfer occurs when `in_valid & in_ready`.
- All `in_*` fields are captured into registers on transfer.
- Inputs are ignored at all other times.

Result arithmetic, all 32-bit with no carries:
- CSRRW: new = src.
- CSRRS: new = old | src.
- CSRRC: new = old & ~src.

Write suppression:
- No write when `in_csr_rd` ≥ 4, i.e. the read-only mvendorid/marchid indices or the unused codes.
- No write for CSRRS or CSRRC when src == 0.
- A suppressed CSR op still passes through the WRITE state with `CSRWr` = 0.

FSM states: IDLE, WRITE, EPC, CAUSE, REDIR. Transitions on transfer from IDLE:
- CSRRW/CSRRS/CSRRC → WRITE.
- ECALL → EPC.
- MRET → REDIR.
- NONE → stays in IDLE.

State behaviour:
- WRITE: `CSRWr` = !suppressed, `WBU_csr_rd` = rd, `csr_busW` = new. Next state IDLE.
- EPC: `CSRWr` = 1, `WBU_csr_rd` = 2, `csr_busW` = latched pc. Next state CAUSE.
- CAUSE: `CSRWr` = 1, `WBU_csr_rd` = 3, `csr_busW` = `ECALL_CAUSE`. Next state REDIR.
- REDIR: `redirect_valid` = 1. `redirect_pc` = latched mtvec for ECALL, latched mepc for MRET. Next state IDLE.

Output rules:
- Outputs are registered (Moore).
- In IDLE: `CSRWr` = 0, `redirect_valid` = 0, and `WBU_csr_rd`/`csr_busW`/`redirect_pc` are 0.
- At most one CSR write occurs per cycle.
- The block does no CSR forwarding. The producer must not present an instruction whose CSR read depends on an in-flight write until `in_ready` returns, so the IDU reads the updated CSR file.

## Timing
Reset values: all outputs 0 except `in_ready` = 1. State is IDLE.

Latency, with transfer at cycle N:
- CSR op: write at N+1; `in_ready` = 1 at N+2.
- ECALL: mepc write at N+1, mcause write at N+2, redirect at N+3; `in_ready` = 1 at N+4.
- MRET: redirect at N+1; `in_ready` = 1 at N+2.
- NONE: `in_ready` stays 1, giving back-to-back acceptance.

Boundary conditions:
- `in_ready` is low in every non-IDLE state, so no request is accepted mid-sequence. `in_valid` may be held high throughout.
- `rst` has priority over every state and forces IDLE and reset outputs in the next cycle.
- A partially completed ECALL (mepc written, mcause not) is abandoned on reset. The CSR file resets on the same `rst`.
- `redirect_valid` is high for exactly one cycle per ECALL or MRET.

## Structure
Shared package `csr_pkg` holds:
- the op enum `csr_op_t` (3 bits);
- CSR index localparams: MSTATUS, MTVEC, MEPC, MCAUSE, MVENDORID, MARCHID;
- the FSM state enum.

The CSR file's index defines must be re-expressed from `csr_pkg` so both blocks share a single source.

One combinational sub-module, `wbu_csr_alu`:
- inputs: op, old, src;
- outputs: new, write_suppress.

Everything else (FSM, capture registers, output registers) lives in `wbu_csr_commit`.

## Test plan
- Reset then idle: `rst` high 2 cycles → `in_ready` = 1, `CSRWr` = 0, `redirect_valid` = 0, `busy` = 0.
- CSRRW mtvec: rd=1, old=0, src=32'h80000100 → N+1: `CSRWr` = 1, `WBU_csr_rd` = 1, `csr_busW` = 32'h80000100, `in_ready` = 0. N+2: `in_ready` = 1.
- CSRRS and CSRRC on mstatus:
  - CSRRS old=32'h1800, src=32'h8 → `csr_busW` = 32'h1808.
  - CSRRC old=32'h1808, src=32'h1800 → `csr_busW` = 32'h8.
  - CSRRS src=0 → `CSRWr` stays 0.
- ECALL pc=32'h80000010, mtvec=32'h80000200:
  - N+1: write rd=2, data 32'h80000010.
  - N+2: write rd=3, data 32'hb.
  - N+3: `redirect_valid` = 1, `redirect_pc` = 32'h80000200.
  - N+4: `in_ready` = 1.
- MRET with mepc=32'h80000014 → N+1: `redirect_pc` = 32'h80000014, `CSRWr` = 0. A second MRET held on `in_valid` is accepted at N+2.
- Read-only index and reset mid-sequence:
  - CSRRW rd=4 → no write, `in_ready` back at N+2.
  - ECALL with `rst` asserted at N+1 → N+2: IDLE, `CSRWr` = 0, no mcause write, no redirect.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR definitions for the write-back commit sequencer and the IDU CSR file.
package csr_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_CSRRW = 3'd1,
    OP_CSRRS = 3'd2,
    OP_CSRRC = 3'd3,
    OP_ECALL = 3'd4,
    OP_MRET  = 3'd5
  } csr_op_t;

  localparam logic [2:0] MSTATUS   = 3'd0;
  localparam logic [2:0] MTVEC     = 3'd1;
  localparam logic [2:0] MEPC      = 3'd2;
  localparam logic [2:0] MCAUSE    = 3'd3;
  localparam logic [2:0] MVENDORID = 3'd4;
  localparam logic [2:0] MARCHID   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_EPC   = 3'd2,
    ST_CAUSE = 3'd3,
    ST_REDIR = 3'd4
  } commit_state_t;

  // Indices from mvendorid upward are read-only or unimplemented.
  function automatic logic csr_is_writable(input logic [2:0] idx);
    return idx < MVENDORID;
  endfunction

endpackage

// File: rtl/wbu_csr_alu.sv
// Combinational read-modify-write result for csrrw/csrrs/csrrc.
module wbu_csr_alu
  import csr_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] old,
  input  logic [31:0] src,
  output logic [31:0] new_val,
  output logic        write_suppress
);

  always_comb begin
    new_val        = old;
    write_suppress = 1'b0;
    case (op)
      OP_CSRRW: new_val = src;
      OP_CSRRS: begin
        new_val        = old | src;
        write_suppress = (src == 32'd0);
      end
      OP_CSRRC: begin
        new_val        = old & ~src;
        write_suppress = (src == 32'd0);
      end
      default: begin
        new_val        = old;
        write_suppress = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wbu_csr_commit.sv
// Write-back CSR commit sequencer: CSR op writes, two-cycle ecall update, trap redirect.
module wbu_csr_commit
  import csr_pkg::*;
#(
  parameter logic [31:0] ECALL_CAUSE = 32'hb
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [2:0]  in_csr_rd,
  input  logic [31:0] in_csr_old,
  input  logic [31:0] in_src,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_mtvec,
  input  logic [31:0] in_mepc,
  output logic        CSRWr,
  output logic [2:0]  WBU_csr_rd,
  output logic [31:0] csr_busW,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  commit_state_t state_q, state_d;
  logic [31:0]   mtvec_q, mtvec_d;
  logic          csr_wr_q, csr_wr_d;
  logic [2:0]    csr_rd_q, csr_rd_d;
  logic [31:0]   csr_bus_q, csr_bus_d;
  logic          redir_valid_q, redir_valid_d;
  logic [31:0]   redir_pc_q, redir_pc_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;

  logic [31:0]   alu_new;
  logic          alu_suppress;

  wbu_csr_alu u_alu (
    .op             (in_op),
    .old            (in_csr_old),
    .src            (in_src),
    .new_val        (alu_new),
    .write_suppress (alu_suppress)
  );

  // Outputs are computed for the state being entered, so every strobe comes from a flop.
  always_comb begin
    state_d       = state_q;
    mtvec_d       = mtvec_q;
    csr_wr_d      = 1'b0;
    csr_rd_d      = 3'd0;
    csr_bus_d     = 32'd0;
    redir_valid_d = 1'b0;
    redir_pc_d    = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mtvec_d = in_mtvec;
          case (csr_op_t'(in_op))
            OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
              state_d   = ST_WRITE;
              csr_wr_d  = !alu_suppress && csr_is_writable(in_csr_rd);
              csr_rd_d  = in_csr_rd;
              csr_bus_d = alu_new;
            end
            OP_ECALL: begin
              state_d   = ST_EPC;
              csr_wr_d  = 1'b1;
              csr_rd_d  = MEPC;
              csr_bus_d = in_pc;
            end
            OP_MRET: begin
              state_d       = ST_REDIR;
              redir_valid_d = 1'b1;
              redir_pc_d    = in_mepc;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_EPC: begin
        state_d   = ST_CAUSE;
        csr_wr_d  = 1'b1;
        csr_rd_d  = MCAUSE;
        csr_bus_d = ECALL_CAUSE;
      end
      ST_CAUSE: begin
        state_d       = ST_REDIR;
        redir_valid_d = 1'b1;
        redir_pc_d    = mtvec_q;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mtvec_q       <= 32'd0;
      csr_wr_q      <= 1'b0;
      csr_rd_q      <= 3'd0;
      csr_bus_q     <= 32'd0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mtvec_q       <= mtvec_d;
      csr_wr_q      <= csr_wr_d;
      csr_rd_q      <= csr_rd_d;
      csr_bus_q     <= csr_bus_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign busy           = busy_q;
  assign CSRWr          = csr_wr_q;
  assign WBU_csr_rd     = csr_rd_q;
  assign csr_busW       = csr_bus_q;
  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_wbu_csr_commit.sv
// Self-checking bench: directed vector table, corner sequences, randomized model comparison.
module tb_wbu_csr_commit;

  localparam logic [31:0] CAUSE = 32'hb;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [2:0]  in_csr_rd;
  logic [31:0] in_csr_old;
  logic [31:0] in_src;
  logic [31:0] in_pc;
  logic [31:0] in_mtvec;
  logic [31:0] in_mepc;
  logic        CSRWr;
  logic [2:0]  WBU_csr_rd;
  logic [31:0] csr_busW;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  wbu_csr_commit #(.ECALL_CAUSE(CAUSE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_csr_rd(in_csr_rd), .in_csr_old(in_csr_old), .in_src(in_src),
    .in_pc(in_pc), .in_mtvec(in_mtvec), .in_mepc(in_mepc),
    .CSRWr(CSRWr), .WBU_csr_rd(WBU_csr_rd), .csr_busW(csr_busW),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [31:0] old,
                       input logic [31:0] src, input logic [31:0] pc,
                       input logic [31:0] mtvec, input logic [31:0] mepc);
    in_op = op; in_csr_rd = rd; in_csr_old = old; in_src = src;
    in_pc = pc; in_mtvec = mtvec; in_mepc = mepc;
  endtask

  task automatic drive_junk();
    drive(3'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [31:0] old;
    logic [31:0] src;
    logic        exp_wr;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [2:0]  rd;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
  } cyc_t;

  vec_t vecs[7];
  cyc_t exp_q[$];

  // Reference: the sequence of per-cycle effects a retiring instruction must produce.
  task automatic model(input logic [2:0] op, input logic [2:0] rd, input logic [31:0] old,
                       input logic [31:0] src, input logic [31:0] pc,
                       input logic [31:0] mtvec, input logic [31:0] mepc);
    cyc_t c;
    logic [31:0] v;
    exp_q.delete();
    c = '{wr: 1'b0, rd: 3'd0, data: 32'd0, rv: 1'b0, rpc: 32'd0};
    if (op >= 1 && op <= 3) begin
      if (op == 1) v = src;
      else if (op == 2) v = old | src;
      else v = old & ~src;
      c.wr = (rd <= 3) && (op == 1 || src != 0);
      c.rd = rd; c.data = v;
      exp_q.push_back(c);
    end else if (op == 4) begin
      c.wr = 1'b1; c.rd = 3'd2; c.data = pc;    exp_q.push_back(c);
      c.wr = 1'b1; c.rd = 3'd3; c.data = CAUSE; exp_q.push_back(c);
      c.wr = 1'b0; c.rd = 3'd0; c.data = 32'd0; c.rv = 1'b1; c.rpc = mtvec; exp_q.push_back(c);
    end else if (op == 5) begin
      c.rv = 1'b1; c.rpc = mepc; exp_q.push_back(c);
    end
  endtask

  task automatic run_txn(input int id, input logic [2:0] op, input logic [2:0] rd,
                         input logic [31:0] old, input logic [31:0] src, input logic [31:0] pc,
                         input logic [31:0] mtvec, input logic [31:0] mepc);
    int nc;
    model(op, rd, old, src, pc, mtvec, mepc);
    nc = exp_q.size();
    chk("rand_ready_pre", in_ready, 1);
    drive(op, rd, old, src, pc, mtvec, mepc);
    in_valid = 1'b1;
    tick();
    // Requests presented mid-sequence must be ignored.
    drive_junk();
    for (int k = 0; k < nc; k++) begin
      chk("rand_wr", CSRWr, exp_q[k].wr);
      if (exp_q[k].wr) begin
        chk("rand_rd", WBU_csr_rd, exp_q[k].rd);
        chk("rand_data", csr_busW, exp_q[k].data);
      end
      chk("rand_rv", redirect_valid, exp_q[k].rv);
      if (exp_q[k].rv) chk("rand_rpc", redirect_pc, exp_q[k].rpc);
      chk("rand_busy_ready", in_ready, 0);
      if (k == nc - 1) begin
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    chk("rand_ready_post", in_ready, 1);
    chk("rand_idle_wr", CSRWr, 0);
    chk("rand_idle_rv", redirect_valid, 0);
    $display("txn %0d op=%0d rd=%0d cycles=%0d", id, op, rd, nc);
  endtask

  initial begin
    in_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    vecs[0] = '{3'd1, 3'd1, 32'h0,    32'h80000100, 1'b1, 32'h80000100};
    vecs[1] = '{3'd2, 3'd0, 32'h1800, 32'h8,        1'b1, 32'h1808};
    vecs[2] = '{3'd3, 3'd0, 32'h1808, 32'h1800,     1'b1, 32'h8};
    vecs[3] = '{3'd2, 3'd0, 32'h1808, 32'h0,        1'b0, 32'h0};
    vecs[4] = '{3'd1, 3'd4, 32'h0,    32'h1234,     1'b0, 32'h0};
    vecs[5] = '{3'd3, 3'd5, 32'hffff, 32'hff,       1'b0, 32'h0};
    vecs[6] = '{3'd1, 3'd3, 32'hdead, 32'h0,        1'b1, 32'h0};

    tick(); tick();
    rst = 1'b0;
    chk("reset_ready", in_ready, 1);
    chk("reset_wr", CSRWr, 0);
    chk("reset_rv", redirect_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_bus", csr_busW, 0);
    $display("txn reset");

    // Single-write CSR ops from the vector table.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].op, vecs[i].rd, vecs[i].old, vecs[i].src, 32'h0, 32'h0, 32'h0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("vec_wr", CSRWr, vecs[i].exp_wr);
      if (vecs[i].exp_wr) begin
        chk("vec_rd", WBU_csr_rd, vecs[i].rd);
        chk("vec_data", csr_busW, vecs[i].exp_data);
      end
      chk("vec_ready_n1", in_ready, 0);
      chk("vec_busy_n1", busy, 1);
      tick();
      chk("vec_ready_n2", in_ready, 1);
      chk("vec_wr_n2", CSRWr, 0);
      $display("txn vec %0d op=%0d rd=%0d data=%h", i, vecs[i].op, vecs[i].rd, csr_busW);
    end

    // ECALL full sequence.
    drive(3'd4, 3'd0, 0, 0, 32'h80000010, 32'h80000200, 32'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ecall_n1_wr", CSRWr, 1);
    chk("ecall_n1_rd", WBU_csr_rd, 2);
    chk("ecall_n1_data", csr_busW, 32'h80000010);
    tick();
    chk("ecall_n2_wr", CSRWr, 1);
    chk("ecall_n2_rd", WBU_csr_rd, 3);
    chk("ecall_n2_data", csr_busW, 32'hb);
    chk("ecall_n2_ready", in_ready, 0);
    tick();
    chk("ecall_n3_wr", CSRWr, 0);
    chk("ecall_n3_rv", redirect_valid, 1);
    chk("ecall_n3_rpc", redirect_pc, 32'h80000200);
    chk("ecall_n3_ready", in_ready, 0);
    tick();
    chk("ecall_n4_ready", in_ready, 1);
    chk("ecall_n4_rv", redirect_valid, 0);
    $display("txn ecall");

    // MRET held on in_valid: second one accepted as soon as ready returns.
    drive(3'd5, 3'd0, 0, 0, 0, 0, 32'h80000014);
    in_valid = 1'b1;
    tick();
    chk("mret_n1_rv", redirect_valid, 1);
    chk("mret_n1_rpc", redirect_pc, 32'h80000014);
    chk("mret_n1_wr", CSRWr, 0);
    chk("mret_n1_ready", in_ready, 0);
    tick();
    chk("mret_n2_rv", redirect_valid, 0);
    chk("mret_n2_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("mret2_rv", redirect_valid, 1);
    tick();
    chk("mret2_rv_once", redirect_valid, 0);
    chk("mret2_ready", in_ready, 1);
    $display("txn mret x2");

    // Reset mid-ECALL abandons the mcause write and redirect.
    drive(3'd4, 3'd0, 0, 0, 32'h80000020, 32'h80000300, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rstmid_n1_wr", CSRWr, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_n2_wr", CSRWr, 0);
    chk("rstmid_n2_busy", busy, 0);
    chk("rstmid_n2_ready", in_ready, 1);
    chk("rstmid_n2_rv", redirect_valid, 0);
    tick();
    chk("rstmid_n3_wr", CSRWr, 0);
    chk("rstmid_n3_rv", redirect_valid, 0);
    $display("txn ecall reset-abort");

    // NONE and reserved codes are accepted back to back with no effect.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive((i == 0) ? 3'd0 : ((i == 1) ? 3'd6 : 3'd7), 3'd1, 32'h5, 32'h5, 0, 0, 0);
      tick();
      chk("none_ready", in_ready, 1);
      chk("none_wr", CSRWr, 0);
      chk("none_busy", busy, 0);
      $display("txn none op=%0d", in_op);
    end
    in_valid = 1'b0;

    // Randomized transactions against the reference model.
    for (int t = 0; t < 200; t++) begin
      logic [2:0]  op;
      logic [31:0] src;
      op  = 3'($urandom_range(0, 7));
      src = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_txn(t, op, 3'($urandom), $urandom, src, $urandom, $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
